bram_request_port: RTL and testbench

Valid/ready request front-end that sits directly upstream of `single_port_bram` and owns all of its ports. It accepts one read or write request per cycle and drives the BRAM write/read ports. It tracks the BRAM's one-cycle registered read latency and returns read data through a 2-entry backpressure-safe response buffer. Optionally, after reset it sweeps the BRAM to zero before accepting traffic.

---
 rtl/bram_request_port.sv | 113 +++++++++++
 tb/tb_bram_request_port.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_request_port.sv
// Valid/ready request front-end owning all ports of a single_port_bram; 2-entry read response buffer.
// Optional post-reset zero sweep of the BRAM enabled by defining BRAM_REQUEST_PORT_CLEAR_EN.
module bram_request_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_REQ_VALID,
  output logic                  o_REQ_READY,
  input  logic                  i_REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] i_REQ_ADDRESS,
  input  logic [DATA_WIDTH-1:0] i_REQ_DATA,
  output logic                  o_RSP_VALID,
  input  logic                  i_RSP_READY,
  output logic [DATA_WIDTH-1:0] o_RSP_DATA,
  output logic                  o_BRAM_WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0] o_BRAM_WRITE_ADDRESS,
  output logic [DATA_WIDTH-1:0] o_BRAM_WRITE_DATA,
  output logic                  o_BRAM_READ_ENABLE,
  output logic [ADDR_WIDTH-1:0] o_BRAM_READ_ADDRESS,
  input  logic [DATA_WIDTH-1:0] i_BRAM_READ_DATA,
  output logic                  o_BUSY
);

  logic                  in_clear;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  accept;
  logic                  pop;
  logic [2:0]            occupancy;

  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];

`ifdef BRAM_REQUEST_PORT_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // The sweep counter wraps back to 0 on the last address, ready for the next reset.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == S_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) state_d = S_RUN;
    end
  end

  assign in_clear = (state_q == S_CLEAR);
  assign clr_addr = clr_addr_q;
`else
  assign in_clear = 1'b0;
  assign clr_addr = '0;
`endif

  // Ready looks at next-cycle occupancy: buffered + in flight, minus this cycle's pop.
  assign pop         = o_RSP_VALID & i_RSP_READY;
  assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign o_REQ_READY = !in_clear && (occupancy < 3'd2);
  assign accept      = i_REQ_VALID & o_REQ_READY;

  assign o_RSP_VALID = (count_q != 2'd0);
  assign o_RSP_DATA  = fifo_q[rd_ptr_q];

  assign o_BRAM_WRITE_ENABLE  = in_clear | (accept & i_REQ_WRITE);
  assign o_BRAM_WRITE_ADDRESS = in_clear ? clr_addr : i_REQ_ADDRESS;
  assign o_BRAM_WRITE_DATA    = in_clear ? '0 : i_REQ_DATA;
  assign o_BRAM_READ_ENABLE   = accept & ~i_REQ_WRITE;
  assign o_BRAM_READ_ADDRESS  = i_REQ_ADDRESS;
  assign o_BUSY               = in_clear;

  always_comb begin
    inflight_d = accept & ~i_REQ_WRITE;
    count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};
    wr_ptr_d   = wr_ptr_q ^ inflight_q;
    rd_ptr_d   = rd_ptr_q ^ pop;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset; count_q alone decides what is valid.
  always_ff @(posedge i_CLK) begin
    if (inflight_q) fifo_q[wr_ptr_q] <= i_BRAM_READ_DATA;
  end

endmodule

// File: tb/tb_bram_request_port.sv
// Bench for bram_request_port with a behavioural BRAM and a transaction-level reference model.
module tb_bram_request_port;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef BRAM_REQUEST_PORT_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          bram_we, bram_re;
  logic [AW-1:0] bram_wa, bram_ra;
  logic [DW-1:0] bram_wd, bram_rdata;
  logic          busy;

  always #5 clk = ~clk;

  bram_request_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_REQ_VALID(req_valid), .o_REQ_READY(req_ready), .i_REQ_WRITE(req_write),
    .i_REQ_ADDRESS(req_addr), .i_REQ_DATA(req_data),
    .o_RSP_VALID(rsp_valid), .i_RSP_READY(rsp_ready), .o_RSP_DATA(rsp_data),
    .o_BRAM_WRITE_ENABLE(bram_we), .o_BRAM_WRITE_ADDRESS(bram_wa), .o_BRAM_WRITE_DATA(bram_wd),
    .o_BRAM_READ_ENABLE(bram_re), .o_BRAM_READ_ADDRESS(bram_ra), .i_BRAM_READ_DATA(bram_rdata),
    .o_BUSY(busy)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 29 + 5);
  endfunction

  // Behavioural single-port BRAM: write at the edge, registered read-first data.
  logic          mem_init = 1'b0;
  logic [DW-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= init_val(i);
    end else begin
      if (bram_we) bram[bram_wa] <= bram_wd;
      if (bram_re) bram_rdata <= bram[bram_ra];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int since_rst = 0;
  bit release_pending = 1'b0;

  typedef struct { logic [7:0] data; int avail; } rsp_t;
  rsp_t          exp_q[$];
  int            outstanding = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  bit            last_acc;
  logic          obs_ready, obs_valid;
  logic [DW-1:0] obs_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic do_cycle(input bit v, input bit w, input logic [3:0] a,
                          input logic [7:0] d, input bit rr);
    bit busy_e, valid_e, pop_e, ready_e, acc_e;
    @(negedge clk);
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 1'b0;
      since_rst = 0;
    end
    req_valid = v; req_write = w; req_addr = a; req_data = d; rsp_ready = rr;
    #1;
    busy_e  = CLEAR_EN && (since_rst < DEPTH);
    valid_e = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    pop_e   = valid_e && rr;
    ready_e = !busy_e && ((outstanding - int'(pop_e)) < 2);
    acc_e   = v && ready_e;
    obs_ready = req_ready; obs_valid = rsp_valid; obs_data = rsp_data;

    chk("req_ready", req_ready, ready_e);
    chk("rsp_valid", rsp_valid, valid_e);
    if (valid_e) chk("rsp_data", rsp_data, exp_q[0].data);
    chk("busy", busy, busy_e);
    chk("count_le_2", dut.count_q <= 2'd2, 1);
    if (busy_e) begin
      chk("clr_we", bram_we, 1);
      chk("clr_waddr", bram_wa, since_rst[3:0]);
      chk("clr_wdata", bram_wd, 0);
    end else begin
      chk("bram_we", bram_we, acc_e && w);
      if (acc_e && w) begin
        chk("bram_waddr", bram_wa, a);
        chk("bram_wdata", bram_wd, d);
      end
    end
    chk("bram_re", bram_re, acc_e && !w);
    if (acc_e && !w) chk("bram_raddr", bram_ra, a);

    if (pop_e) begin
      void'(exp_q.pop_front());
      outstanding--;
    end
    if (acc_e && w) ref_mem[a] = d;
    if (acc_e && !w) begin
      exp_q.push_back('{data: ref_mem[a], avail: cyc + 2});
      outstanding++;
    end
    last_acc = acc_e;
    @(posedge clk);
    cyc++;
    since_rst++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 4'd5; req_data = 8'h77; rsp_ready = 1'b1;
    #1;
    exp_q.delete();
    outstanding = 0;
    if (CLEAR_EN) for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_re", bram_re, 0);
    chk("rst_busy", busy, CLEAR_EN);
    chk("rst_ready", req_ready, !CLEAR_EN);
    chk("rst_we", bram_we, CLEAR_EN);
    chk("rst_waddr", bram_wa, CLEAR_EN ? 4'd0 : 4'd5);
    chk("rst_wdata", bram_wd, CLEAR_EN ? 8'h00 : 8'h77);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid_hold", rsp_valid, 0);
    cyc += 2;
    release_pending = 1'b1;
  endtask

  typedef struct {
    bit v; bit w; logic [3:0] a; logic [7:0] d; bit rr;
    bit er; bit ev; logic [7:0] ed;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit v, input bit w, input logic [3:0] a, input logic [7:0] d,
                     input bit rr, input bit er, input bit ev, input logic [7:0] ed);
    vt.push_back('{v: v, w: w, a: a, d: d, rr: rr, er: er, ev: ev, ed: ed});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc;
    int stale;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_init = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    do_reset();

    // Hold a read of address 3 from reset release; it waits out the sweep when enabled.
    acc_cyc = -1;
    for (int k = 0; k < 40 && acc_cyc < 0; k++) begin
      do_cycle(1, 0, 4'd3, 8'h00, 1);
      if (last_acc) acc_cyc = k;
    end
    chk("first_accept_cycle", acc_cyc, CLEAR_EN ? 16 : 0);
    do_cycle(0, 0, 4'd0, 8'h00, 1);
    do_cycle(0, 0, 4'd0, 8'h00, 1);
    chk("first_rsp", {obs_valid, obs_data}, {1'b1, CLEAR_EN ? 8'h00 : init_val(3)});
    repeat (2) do_cycle(0, 0, 4'd0, 8'h00, 1);

    // Directed table: write/read ordering, back-to-back reads, backpressure, read-then-write.
    add(1, 1, 4'd0, 8'h2A, 1, 1, 0, 8'h00);
    add(1, 0, 4'd0, 8'h00, 1, 1, 0, 8'h00);
    add(1, 1, 4'd3, 8'hFE, 1, 1, 0, 8'h00);
    add(1, 1, 4'd8, 8'h2E, 1, 1, 1, 8'h2A);
    add(1, 0, 4'd3, 8'h00, 1, 1, 0, 8'h00);
    add(1, 0, 4'd8, 8'h00, 1, 1, 0, 8'h00);
    add(1, 0, 4'd3, 8'h00, 1, 1, 1, 8'hFE);
    add(0, 0, 4'd0, 8'h00, 1, 1, 1, 8'h2E);
    add(0, 0, 4'd0, 8'h00, 1, 1, 1, 8'hFE);
    add(0, 0, 4'd0, 8'h00, 1, 1, 0, 8'h00);
    add(1, 0, 4'd3, 8'h00, 0, 1, 0, 8'h00);
    add(1, 0, 4'd8, 8'h00, 0, 1, 0, 8'h00);
    add(1, 0, 4'd3, 8'h00, 0, 0, 1, 8'hFE);
    add(1, 0, 4'd3, 8'h00, 0, 0, 1, 8'hFE);
    add(1, 0, 4'd3, 8'h00, 0, 0, 1, 8'hFE);
    add(1, 0, 4'd3, 8'h00, 1, 1, 1, 8'hFE);
    add(1, 0, 4'd8, 8'h00, 1, 1, 1, 8'h2E);
    add(0, 0, 4'd0, 8'h00, 1, 1, 1, 8'hFE);
    add(0, 0, 4'd0, 8'h00, 1, 1, 1, 8'h2E);
    add(0, 0, 4'd0, 8'h00, 1, 1, 0, 8'h00);
    add(1, 0, 4'd8, 8'h00, 1, 1, 0, 8'h00);
    add(1, 1, 4'd8, 8'h11, 1, 1, 0, 8'h00);
    add(0, 0, 4'd0, 8'h00, 1, 1, 1, 8'h2E);
    add(1, 0, 4'd8, 8'h00, 1, 1, 0, 8'h00);
    add(0, 0, 4'd0, 8'h00, 1, 1, 0, 8'h00);
    add(0, 0, 4'd0, 8'h00, 1, 1, 1, 8'h11);
    foreach (vt[i]) begin
      do_cycle(vt[i].v, vt[i].w, vt[i].a, vt[i].d, vt[i].rr);
      chk("vec_ready", obs_ready, vt[i].er);
      chk("vec_rsp_valid", obs_valid, vt[i].ev);
      if (vt[i].ev) chk("vec_rsp_data", obs_data, vt[i].ed);
    end

    // Reset with one response buffered and one read in flight.
    do_cycle(1, 0, 4'd3, 8'h00, 0);
    do_cycle(1, 0, 4'd8, 8'h00, 0);
    do_reset();
    stale = 0;
    for (int k = 0; k < 24; k++) begin
      do_cycle(0, 0, 4'd0, 8'h00, 1);
      if (obs_valid) stale++;
    end
    chk("no_stale_rsp", stale, 0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 700; k++) begin
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               4'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)),
               $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 6; k++) do_cycle(0, 0, 4'd0, 8'h00, 1);
    chk("drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
